// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Registered, flow-controlled Rijndael ShiftRows / InvShiftRows stage for block
// widths of 4, 6 or 8 columns. The row permutation is applied combinationally
// to in_data and captured into the output register when a beat is accepted, so
// there is no combinational path from in_data to out_data. A sideband tag
// travels with each beat unmodified.
//
// Build option:
//   SHIFT_ROWS_SKID_EN  - adds a one-entry skid register. in_ready becomes a
//                         flop output with no path from out_ready. When the
//                         macro is undefined the stage is a single register
//                         and in_ready = !out_valid || out_ready.
//
// Parameters:
//   NB     number of state columns (4, 6 or 8)
//   TAG_W  sideband tag width (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   stage can accept a beat
//   in_inv     0 = ShiftRows, 1 = InvShiftRows (bound to the accepted beat)
//   in_data    state, byte (r,c) at in_data[32c+8r +: 8]
//   in_tag     sideband tag
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   shifted state, same packing as in_data
//   out_tag    tag of the beat on out_data
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [32*NB-1:0]   in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Register occupancy: ST_TWO is only reachable with the skid register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Row offsets: rows 2 and 3 shift further for the 8-column block.
  function automatic int row_off(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  // Pure byte permutation; row 0 always maps to itself.
  function automatic logic [W-1:0] shift_state(input logic [W-1:0] d,
                                               input logic         inv);
    logic [W-1:0] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        int src;
        src = inv ? (c - row_off(r) + NB) % NB : (c + row_off(r)) % NB;
        o[32*c + 8*r +: 8] = d[32*src + 8*r +: 8];
      end
    end
    return o;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_data;
  logic [TAG_W-1:0] r_tag;
  logic [W-1:0]     w_shifted;
  logic [W-1:0]     w_main_d;
  logic [TAG_W-1:0] w_main_tag_d;
  logic             w_accept;
  logic             w_deliver;
  logic             w_load_main;

  assign w_shifted = shift_state(in_data, in_inv);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_data;
  assign out_tag   = r_tag;

`ifdef SHIFT_ROWS_SKID_EN
  logic [W-1:0]     r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_in_ready;
  logic             w_main_from_skid;
  logic             w_load_skid;

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          // Output stalled: main holds, the new beat parks in the skid.
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_deliver) begin
          w_state_nxt      = ST_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  assign w_main_d     = w_main_from_skid ? r_skid_data : w_shifted;
  assign w_main_tag_d = w_main_from_skid ? r_skid_tag  : in_tag;
  assign in_ready     = r_in_ready;

  // NOTE: the skid data is reset along with the control bits so a reset can
  // never leave a stale beat to be promoted later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_data <= '0;
      r_skid_tag  <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_load_skid) begin
        r_skid_data <= w_shifted;
        r_skid_tag  <= in_tag;
      end
      // Registered from next state so out_ready never reaches in_ready.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end
`else
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        // Accept in ONE implies out_ready, so the old beat leaves as the
        // new one loads.
        if (w_accept) begin
          w_load_main = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  assign w_main_d     = w_shifted;
  assign w_main_tag_d = in_tag;
  assign in_ready     = (r_state == ST_EMPTY) || out_ready;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_data <= w_main_d;
        r_tag  <= w_main_tag_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Scoreboard bench for shift_rows_pipe. Two instances: NB=4 and NB=8, sharing
// clock, reset and out_ready. Drivers push the model's expected beat when an
// accept is seen; monitors pop and compare on every delivery. The NB=4 monitor
// also tracks occupancy to check in_ready/out_valid and output holding.
// Compile with +define+SHIFT_ROWS_SKID_EN to match a skid-enabled build.
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ordy;
  bit           rnd_en;

  logic         iv4, ir4, inv4, ov4;
  logic [127:0] id4, od4;
  logic [3:0]   it4, ot4;

  logic         iv8, ir8, inv8, ov8;
  logic [255:0] id8, od8;
  logic [3:0]   it8, ot8;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   dels4 = 0;
  bit   ir_low_seen;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_inv(inv4), .in_data(id4), .in_tag(it4),
    .out_valid(ov4), .out_ready(ordy), .out_data(od4), .out_tag(ot4)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_inv(inv8), .in_data(id8), .in_tag(it8),
    .out_valid(ov8), .out_ready(ordy), .out_data(od8), .out_tag(ot8)
  );

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: treat the state as a 4 x nb byte matrix and rotate each row.
  function automatic logic [255:0] model(input logic [255:0] d, input logic inv,
                                         input int nb);
    logic [7:0]   s[4][8];
    int           off[4];
    int           src;
    logic [255:0] o;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) s[r][c] = d[32*c + 8*r +: 8];
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        o[32*c + 8*r +: 8] = s[r][src];
      end
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send4(input logic [127:0] d, input logic inv, input logic [3:0] tag);
    bit   acc = 1'b0;
    int   guard = 0;
    exp_t e;
    iv4 = 1'b1; id4 = d; inv4 = inv; it4 = tag;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (ir4) begin
        acc    = 1'b1;
        e.data = model({128'b0, d}, inv, 4);
        e.tag  = tag;
        q4.push_back(e);
      end
      @(posedge clk); #1;
      guard++;
    end
    iv4 = 1'b0;
    check("send4 accepted", {255'b0, acc}, 256'd1);
  endtask

  task automatic send8(input logic [255:0] d, input logic inv, input logic [3:0] tag);
    bit   acc = 1'b0;
    int   guard = 0;
    exp_t e;
    iv8 = 1'b1; id8 = d; inv8 = inv; it8 = tag;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (ir8) begin
        acc    = 1'b1;
        e.data = model(d, inv, 8);
        e.tag  = tag;
        q8.push_back(e);
      end
      @(posedge clk); #1;
      guard++;
    end
    iv8 = 1'b0;
    check("send8 accepted", {255'b0, acc}, 256'd1);
  endtask

  task automatic drain();
    int guard = 0;
    rnd_en = 1'b0;
    ordy   = 1'b1;
    while ((q4.size() != 0 || q8.size() != 0) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("q4 drained", 256'(q4.size()), 256'd0);
    check("q8 drained", 256'(q8.size()), 256'd0);
  endtask

  // Random out_ready when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_en) ordy = 1'($urandom_range(0, 1));
  end

  // NB=4 monitor: scoreboard, hold rule and occupancy.
  initial begin
    bit           stalled = 1'b0;
    logic [127:0] held_d;
    logic [3:0]   held_t;
    int           cnt = 0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        cnt     = 0;
      end else begin
        if (stalled && ov4) begin
          check("hold data", {128'b0, od4}, {128'b0, held_d});
          check("hold tag", {252'b0, ot4}, {252'b0, held_t});
        end
        stalled = ov4 && !ordy;
        held_d  = od4;
        held_t  = ot4;
`ifdef SHIFT_ROWS_SKID_EN
        check("in_ready4", {255'b0, ir4}, {255'b0, (cnt < 2)});
`else
        check("in_ready4", {255'b0, ir4}, {255'b0, (cnt == 0) || ordy});
`endif
        check("out_valid4", {255'b0, ov4}, {255'b0, (cnt > 0)});
        if (!ir4) ir_low_seen = 1'b1;
        if (ov4 && ordy) begin
          dels4++;
          if (q4.size() == 0) begin
            check("spurious delivery4", 256'(q4.size()), 256'd1);
          end else begin
            e = q4.pop_front();
            check("data4", {128'b0, od4}, e.data);
            check("tag4", {252'b0, ot4}, {252'b0, e.tag});
          end
        end
        cnt = cnt + ((iv4 && ir4) ? 1 : 0) - ((ov4 && ordy) ? 1 : 0);
      end
    end
  end

  // NB=8 monitor: scoreboard only.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ov8 && ordy) begin
        if (q8.size() == 0) begin
          check("spurious delivery8", 256'(q8.size()), 256'd1);
        end else begin
          e = q8.pop_front();
          check("data8", od8, e.data);
          check("tag8", {252'b0, ot8}, {252'b0, e.tag});
        end
      end
    end
  end

  initial begin
    logic [127:0] vec_in, vec_out;
    logic [255:0] d8;
    int           c0, d0;

    rst_n = 1'b0; ordy = 1'b0; rnd_en = 1'b0;
    iv4 = 1'b0; inv4 = 1'b0; id4 = '0; it4 = '0;
    iv8 = 1'b0; inv8 = 1'b0; id8 = '0; it8 = '0;
    #1;
    check("reset out_valid4", {255'b0, ov4}, 256'd0);
    check("reset out_data4", {128'b0, od4}, 256'd0);
    check("reset out_tag4", {252'b0, ot4}, 256'd0);
    check("reset out_valid8", {255'b0, ov8}, 256'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready4 after reset", {255'b0, ir4}, 256'd1);
    check("in_ready8 after reset", {255'b0, ir8}, 256'd1);

    // Known vector, forward, then inverse round trip.
    ordy    = 1'b1;
    vec_in  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    vec_out = 128'h0b06010c_07020d08_030e0904_0f0a0500;
    send4(vec_in, 1'b0, 4'h5);
    check("vector fwd valid", {255'b0, ov4}, 256'd1);
    check("vector fwd data", {128'b0, od4}, {128'b0, vec_out});
    check("vector fwd tag", {252'b0, ot4}, 256'd5);
    send4(vec_out, 1'b1, 4'h6);
    check("vector inv data", {128'b0, od4}, {128'b0, vec_in});

    // Alternating modes back to back.
    for (int i = 0; i < 8; i++) send4(rnd256()[127:0], 1'(i), 4'(i));
    drain();

    // NB=8 forward with byte (r,c) = 8c+r.
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++) d8[32*c + 8*r +: 8] = 8'(8*c + r);
    send8(d8, 1'b0, 4'h9);
    check("nb8 r2c0", {248'b0, od8[16 +: 8]}, 256'd26);
    check("nb8 r3c0", {248'b0, od8[24 +: 8]}, 256'd35);
    check("nb8 r1c7", {248'b0, od8[32*7 + 8 +: 8]}, 256'd1);
    send8(od8, 1'b1, 4'ha);
    check("nb8 round trip", od8, d8);
    for (int i = 0; i < 6; i++) send8(rnd256(), 1'($urandom_range(0, 1)), 4'(i));
    drain();

    // Backpressure: tags 1..10 with random out_ready.
    rnd_en = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      send4(rnd256()[127:0], 1'($urandom_range(0, 1)), 4'(t));
      send8(rnd256(), 1'($urandom_range(0, 1)), 4'(t));
    end
    drain();

    // Full throughput: 16 beats in 16 cycles.
    ordy = 1'b1;
    ir_low_seen = 1'b0;
    c0 = cyc;
    d0 = dels4;
    for (int i = 0; i < 16; i++) send4(rnd256()[127:0], 1'(i >> 1), 4'(i));
    check("throughput accept cycles", 256'(cyc - c0), 256'd16);
    @(posedge clk); #1;
    check("throughput deliveries", 256'(dels4 - d0), 256'd16);
    check("throughput in_ready", {255'b0, ir_low_seen}, 256'd0);
    drain();

    // Reset with beats held.
    ordy = 1'b0;
    send4(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 4'h3);
`ifdef SHIFT_ROWS_SKID_EN
    send4(128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 1'b1, 4'h4);
    check("two held in_ready", {255'b0, ir4}, 256'd0);
`endif
    send8(rnd256(), 1'b0, 4'h7);
    rst_n = 1'b0;
    #1;
    q4.delete();
    q8.delete();
    check("midreset out_valid4", {255'b0, ov4}, 256'd0);
    check("midreset out_data4", {128'b0, od4}, 256'd0);
    check("midreset out_tag4", {252'b0, ot4}, 256'd0);
    check("midreset out_valid8", {255'b0, ov8}, 256'd0);
    check("midreset out_data8", od8, 256'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready4 after midreset", {255'b0, ir4}, 256'd1);
    ordy = 1'b1;
    send4(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0, 4'hc);
    send8(rnd256(), 1'b1, 4'hd);
    drain();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

- Registered, flow-controlled AES/Rijndael ShiftRows stage.
- Applies forward ShiftRows or InvShiftRows to one state per beat.
- Parametrised for Rijndael block widths of 4, 6 or 8 columns, with a passthrough sideband tag.
- Sits between SubBytes and MixColumns in the round datapath, and in reverse order in the decrypt path. It replaces the purely combinational row shifter wherever backpressure or a register boundary is needed.

## Interface
Parameters:
- NB, 4, number of state columns; legal values are 4, 6 and 8. Any other value is an elaboration error via $error.
- TAG_W, 4, width of the sideband tag carried alongside each state (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled per beat.
- in_data  input  32*NB  state; byte (r,c) is in_data[32c+8r +: 8].
- in_tag  input  TAG_W  sideband, passed through unmodified.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32*NB  shifted state, same byte packing as in_data.
- out_tag  output  TAG_W  tag of the beat on out_data.

## Operation
- Row offsets C_r are (0,1,2,3) for NB=4 and NB=6, and (0,1,3,4) for NB=8.
- Forward: out(r,c) = in(r,(c+C_r) mod NB).
- Inverse: out(r,c) = in(r,(c−C_r+NB) mod NB).
- The shift is combinational on in_data and is captured into the output register on accept.
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- The transform, in_inv and in_tag are all bound to the accepted beat. A mode change between beats takes effect on the next accepted beat, with no bubble.
- Order is strictly preserved; no beat is dropped or duplicated while rst_n is high.
- Row 0 is never moved. Bytes only permute; no byte value is altered.
- Holding rule: while out_valid && !out_ready, out_data and out_tag must stay stable.
- States (register occupancy): EMPTY, ONE (main register full), TWO (main and skid full; only when the skid is enabled).

## Timing
- Reset (async assert, sync release on clk):
  - out_valid = 0, out_data = 0, out_tag = 0.
  - The skid register is cleared.
  - in_ready = 1 from the first clock after release.
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N. This is 1 cycle, with no combinational in→out data path.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous accept and deliver in ONE: the main register reloads with the new beat and out_valid stays 1.
- Reset asserted mid-operation: all held beats are discarded immediately. Outputs go to their reset values asynchronously.

## Configuration
- SHIFT_ROWS_SKID_EN defined:
  - Adds a one-entry skid register.
  - in_ready is a registered signal, = !skid_full, with no combinational path from out_ready.
  - EMPTY→ONE on accept.
  - ONE→TWO on accept while the output is stalled; the stalled output register holds, and the new beat goes to skid.
  - TWO→ONE on deliver; the skid moves to main.
  - in_ready = 0 only in TWO.
- SHIFT_ROWS_SKID_EN undefined:
  - Single register stage, no TWO state.
  - in_ready = !out_valid || out_ready, which is a combinational path from out_ready.
  - Same latency and reset values.

## Test plan
- Forward, NB=4, out_ready=1, inputs in_inv=0, in_data=128'h0f0e0d0c_0b0a0908_07060504_03020100, in_tag=4'h5 → one cycle later: out_valid=1, out_data=128'h0b06010c_07020d08_030e0904_0f0a0500, out_tag=4'h5.
- Inverse round trip: feed that output back with in_inv=1 → the original 128'h0f0e…0100 is returned. Also run back-to-back beats alternating in_inv each cycle; each beat must get its own mode.
- NB=8, forward, byte (r,c)=8c+r:
  - row 2 output column 0 holds input column 3; row 3 output column 0 holds input column 4; row 1 output column 7 holds input column 0.
  - Compare all 32 bytes against the reference model.
- Backpressure: stream tags 1..10 with out_ready toggling at random (50%). Check:
  - all 10 tags are delivered in order, with data matching the model;
  - out_data is stable while stalled;
  - with SKID_EN, in_ready is low exactly in the cycles after two beats are held.
- Full throughput: 16 consecutive beats with out_ready=1 → 16 deliveries in 16 consecutive cycles, in_ready constantly 1.
- Reset mid-stream: assert rst_n=0 while two beats are held (SKID_EN) → out_valid=0 and out_data=0 immediately. After release, in_ready=1, and the next beat emerges with no stale data.
